pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core. Arbitrates load-use, branch, data-memory wait and
//  multi-cycle mul/div requests into per-stage stall/flush/bubble controls.
//  Holds the wait-state FSM, the mul/div start handshake, a wait watchdog and perf counters.
//  Sits beside the hazard detection logic; drives the IF/ID/EX/MEM/WB pipeline register enables.
// PARAMETERS
//  CNT_W        32    width of perf counters (saturating)
//  TIMEOUT_CYC  1024  cycles in a wait state before err_timeout sets (>=2)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      synchronous reset, active-high
//  lu_hazard      in   1      load in EX, its rd matches an ID source
//  branch_taken   in   1      EX-stage branch/jump resolved taken
//  dmem_req       in   1      MEM stage holds a load/store
//  dmem_ready     in   1      data memory completes MEM access this cycle
//  md_req         in   1      EX stage holds a mul/div op (level)
//  md_done        in   1      mul/div result valid this cycle (pulse)
//  md_go          out  1      one-cycle start pulse to mul/div unit
//  if_stall       out  1      hold PC / IF-ID register
//  id_stall       out  1      hold ID-EX register
//  ex_stall       out  1      hold EX-MEM register
//  mem_stall      out  1      hold MEM-WB register
//  id_flush       out  1      bubble into ID-EX
//  ex_flush       out  1      bubble into EX-MEM (ID-EX for load-use)
//  mem_flush      out  1      bubble into MEM-WB
//  wb_bubble      out  1      suppress WB write this cycle
//  err_timeout    out  1      sticky: wait exceeded TIMEOUT_CYC
//  stall_cnt      out  CNT_W  cycles with if_stall=1
//  flush_cnt      out  CNT_W  taken-branch flushes applied
// BEHAVIOUR
//  FSM states: RUN, DMEM_WAIT, MD_WAIT. Reset -> RUN; counters, err_timeout, watchdog = 0.
//  While rst=1 every control output is 0.
//  Stall/flush outputs are combinational from state+inputs. No added latency.
//  dm = dmem_req & !dmem_ready (evaluated in RUN and DMEM_WAIT).
//  Priority, highest first:
//   1 dm: if/id/ex/mem_stall=1, wb_bubble=1, all flushes 0. RUN->DMEM_WAIT; stay while dm.
//     dmem_ready=1 releases in the same cycle -> RUN.
//   2 mul/div: in RUN, md_req & !md_done & !dm -> md_go=1 (exactly one cycle) and -> MD_WAIT.
//     In MD_WAIT: if/id/ex_stall=1, mem_flush=1 until md_done.
//     The md_done cycle releases the stall (EX advances) -> RUN; md_go never reissued for that op.
//     The entry cycle also asserts if/id/ex_stall and mem_flush.
//     RUN & md_req & md_done: no stall, no md_go.
//     dmem_req ignored in MD_WAIT (MEM holds bubbles).
//   3 branch_taken (EX advancing): id_flush=ex_flush=1, no stalls; flush_cnt++.
//     Overrides lu_hazard (squashed ID op).
//   4 lu_hazard: if_stall=id_stall=1, ex_flush=1 for one cycle (load advances, hazard clears).
//  A branch or lu_hazard present during dm/MD_WAIT is not acted on.
//  It is re-evaluated in the release cycle, when EX advances.
//  Watchdog: clears on each wait-state entry, +1 per cycle in DMEM_WAIT/MD_WAIT.
//   Reaching TIMEOUT_CYC sets err_timeout (held until rst). The FSM keeps waiting; no abort.
//  Counters saturate at all-ones; no wrap.
//  rst mid-wait: next cycle RUN, md_go not pending, stalls drop.
// TESTING
//  T1 lu_hazard=1 one cycle in RUN -> if_stall=id_stall=ex_flush=1 that cycle only; stall_cnt=1.
//  T2 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 cycles of all stalls + wb_bubble.
//     4th cycle clear; state RUN.
//  T3 md_req=1, md_done after 5 cycles -> md_go single pulse on cycle 0.
//     Stalls + mem_flush cycles 0-4, clear on done cycle.
//  T4 branch_taken with lu_hazard same cycle -> id_flush=ex_flush=1, if_stall=0, flush_cnt=1.
//  T5 branch_taken during DMEM_WAIT -> no flush until the dmem_ready cycle, then flush once.
//  T6 TIMEOUT_CYC=4, dmem_ready=0 for 6 cycles -> err_timeout rises after 4 wait cycles.
//     Stays 1 until rst.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage core. Turns load-use,
//   taken-branch, data-memory wait and multi-cycle mul/div requests into
//   per-stage stall/flush/bubble controls for the IF/ID/EX/MEM/WB pipeline
//   registers. Also owns the wait-state FSM, the mul/div start handshake,
//   a wait watchdog and two saturating performance counters.
//
// Parameters
//   CNT_W        width of the saturating perf counters
//   TIMEOUT_CYC  cycles spent in a wait state before err_timeout sets (>=2)
//
// Ports
//   clk, rst       clock (rising edge) / synchronous active-high reset
//   lu_hazard      load in EX whose rd matches an ID source
//   branch_taken   EX-stage branch/jump resolved taken
//   dmem_req       MEM stage holds a load/store
//   dmem_ready     data memory completes the MEM access this cycle
//   md_req         EX stage holds a mul/div op (level)
//   md_done        mul/div result valid this cycle (pulse)
//   md_go          one-cycle start pulse to the mul/div unit
//   if/id/ex/mem_stall   hold PC+IF-ID / ID-EX / EX-MEM / MEM-WB registers
//   id/ex/mem_flush      inject a bubble into ID-EX / EX-MEM / MEM-WB
//   wb_bubble      suppress the WB register-file write this cycle
//   err_timeout    sticky: a wait lasted TIMEOUT_CYC cycles
//   stall_cnt      cycles with if_stall=1 (saturating)
//   flush_cnt      taken-branch flushes applied (saturating)
// ----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_hazard,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             md_req,
    input  logic             md_done,
    output logic             md_go,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             wb_bubble,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        MD_WAIT   = 2'd2
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state;
    state_t            w_next;
    logic [WD_W-1:0]   r_wd;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              w_dm;
    logic              w_eval;

    assign w_dm = dmem_req & ~dmem_ready;

    // Controls are combinational from state + inputs so a hazard is acted on
    // in the very cycle it appears.
    always_comb begin
        md_go     = 1'b0;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        mem_stall = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        mem_flush = 1'b0;
        wb_bubble = 1'b0;
        w_eval    = 1'b0;
        w_next    = r_state;

        if (rst) begin
            w_next = RUN;
        end else begin
            case (r_state)
                MD_WAIT: begin
                    // MEM only holds bubbles here, so dmem_req is ignored.
                    if (!md_done) begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_stall  = 1'b1;
                        mem_flush = 1'b1;
                    end else begin
                        // Release cycle: EX advances, so branch / load-use
                        // held back during the wait are acted on now.
                        w_next = RUN;
                        w_eval = 1'b1;
                    end
                end
                default: begin
                    // RUN and DMEM_WAIT share one decision: a DMEM_WAIT cycle
                    // with dmem_ready=1 behaves exactly like RUN.
                    if (w_dm) begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_stall  = 1'b1;
                        mem_stall = 1'b1;
                        wb_bubble = 1'b1;
                        w_next    = DMEM_WAIT;
                    end else if (md_req && !md_done) begin
                        // Entry cycle already stalls; md_go fires only here,
                        // so it cannot be reissued while the op is pending.
                        md_go     = 1'b1;
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_stall  = 1'b1;
                        mem_flush = 1'b1;
                        w_next    = MD_WAIT;
                    end else begin
                        w_next = RUN;
                        w_eval = 1'b1;
                    end
                end
            endcase

            if (w_eval) begin
                // A taken branch squashes the ID op, so it outranks load-use.
                if (branch_taken) begin
                    id_flush = 1'b1;
                    ex_flush = 1'b1;
                end else if (lu_hazard) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_wd        <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;

            // Watchdog restarts on every entry into a wait state (including
            // DMEM_WAIT release straight into a mul/div start).
            if (w_next != RUN && w_next != r_state) begin
                r_wd <= '0;
            end else if (r_state != RUN) begin
                if (r_wd != WD_W'(TIMEOUT_CYC))
                    r_wd <= r_wd + 1'b1;
                if (r_wd >= WD_W'(TIMEOUT_CYC - 1))
                    r_err <= 1'b1;
            end

            if (if_stall && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (id_flush && r_flush_cnt != {CNT_W{1'b1}})
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign err_timeout = r_err;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
